gear_shift_monitor: RTL and testbench

//   Closed-loop confirmation for gearbox shifts. Accepts a shift command (direction + target gear)

---
 rtl/gear_pkg.sv | 27 ++
 rtl/gear_shift_if.sv | 18 +
 rtl/gear_shift_monitor_gps_debounce.sv | 43 ++++
 rtl/gear_shift_monitor.sv | 112 +++++++++++
 tb/tb_gear_shift_monitor.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gear_pkg.sv
// Shared gearbox types and default timing for the shift monitor and the shifter controller.
// Defaults assume a 50 MHz clock.
package gear_pkg;

  typedef enum logic [2:0] {
    NEUTRAL = 3'd0,
    FIRST   = 3'd1,
    SECOND  = 3'd2,
    THIRD   = 3'd3,
    FOURTH  = 3'd4,
    FIFTH   = 3'd5,
    SIXTH   = 3'd6,
    BETWEEN = 3'd7
  } gear_e;

  typedef enum logic [1:0] {
    OK         = 2'd0,
    TIMEOUT    = 2'd1,
    WRONG_GEAR = 2'd2,
    BAD_CMD    = 2'd3
  } result_e;

  localparam int DEF_DEBOUNCE_CYCLES = 50000;    // 1 ms
  localparam int DEF_SHIFT_TIMEOUT   = 5000000;  // 100 ms
  localparam int DEF_NEUTRAL_TIMEOUT = 2500000;  // 50 ms

endpackage

// File: rtl/gear_shift_if.sv
// Shift command handshake and result status between the shifter controller and the monitor.
interface gear_shift_if;
  import gear_pkg::*;

  logic    cmd_valid;
  logic    cmd_ready;
  logic    cmd_dir;
  gear_e   cmd_target;
  logic    act_dir;    // direction of the shift being / last monitored
  logic    busy;
  logic    done;
  result_e result;

  modport master (output cmd_valid, cmd_dir, cmd_target,
                  input  cmd_ready, act_dir, busy, done, result);
  modport slave  (input  cmd_valid, cmd_dir, cmd_target,
                  output cmd_ready, act_dir, busy, done, result);
endinterface

// File: rtl/gear_shift_monitor_gps_debounce.sv
// Gear position sensor path: 2-FF synchroniser then a hold counter; the code must stay
// unchanged for DEBOUNCE_CYCLES before it is published as gear_stable.
module gps_debounce import gear_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] gps_raw,
  output gear_e      gear_stable,
  output logic       gear_stable_valid
);

  localparam int                CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0]       gpsMeta;
  logic [2:0]       gpsSync;
  logic [CNT_W-1:0] holdCnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpsMeta           <= '0;
      gpsSync           <= '0;
      holdCnt           <= '0;
      gear_stable       <= NEUTRAL;
      gear_stable_valid <= 1'b0;
    end else begin
      gpsMeta <= gps_raw;
      gpsSync <= gpsMeta;
      // A mismatch between the two stages means gpsSync is about to change: restart the hold.
      if (gpsMeta != gpsSync) begin
        holdCnt <= '0;
      end else if (holdCnt == CNT_LAST) begin
        gear_stable       <= gear_e'(gpsSync);
        gear_stable_valid <= 1'b1;
      end else begin
        holdCnt <= holdCnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/gear_shift_monitor.sv
// Closed-loop shift confirmation: accepts a command, watches the debounced gear code until it
// reaches the target, strays to another gear, or the window expires, then pulses done.
module gear_shift_monitor import gear_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SHIFT_TIMEOUT   = DEF_SHIFT_TIMEOUT,
  parameter int NEUTRAL_TIMEOUT = DEF_NEUTRAL_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst_n,
  gear_shift_if.slave  shiftIf,
  input  logic [2:0]   gps_raw,
  output gear_e        gear_stable,
  output logic         gear_stable_valid,
  output logic         fault,
  input  logic         fault_clr
);

  typedef enum logic [1:0] {IDLE, ACTIVE, REPORT} state_e;

  state_e      state,     stateNext;
  logic [31:0] timer,     timerNext;
  gear_e       target,    targetNext;
  gear_e       startGear, startNext;
  result_e     resultReg, resultNext;
  logic        actDir,    dirNext;
  logic        outOfReset;
  logic        accept;

  gps_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_gps_debounce (
    .clk               (clk),
    .rst_n             (rst_n),
    .gps_raw           (gps_raw),
    .gear_stable       (gear_stable),
    .gear_stable_valid (gear_stable_valid)
  );

  assign shiftIf.cmd_ready = outOfReset && (state == IDLE);
  assign shiftIf.busy      = (state == ACTIVE);
  assign shiftIf.done      = (state == REPORT);
  assign shiftIf.result    = resultReg;
  assign shiftIf.act_dir   = actDir;
  assign accept            = shiftIf.cmd_valid && shiftIf.cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      target     <= NEUTRAL;
      startGear  <= NEUTRAL;
      resultReg  <= OK;
      actDir     <= 1'b0;
      outOfReset <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= stateNext;
      timer      <= timerNext;
      target     <= targetNext;
      startGear  <= startNext;
      resultReg  <= resultNext;
      actDir     <= dirNext;
      outOfReset <= 1'b1;
      // Set takes priority over a simultaneous clear so a fresh fault is never lost.
      if (state == REPORT && resultReg != OK) fault <= 1'b1;
      else if (fault_clr)                     fault <= 1'b0;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    stateNext  = state;
    timerNext  = timer;
    targetNext = target;
    startNext  = startGear;
    resultNext = resultReg;
    dirNext    = actDir;
    unique case (state)
      IDLE: begin
        if (accept) begin
          dirNext = shiftIf.cmd_dir;
          if (shiftIf.cmd_target == BETWEEN) begin
            resultNext = BAD_CMD;
            stateNext  = REPORT;
          end else begin
            targetNext = shiftIf.cmd_target;
            startNext  = gear_stable;
            timerNext  = (shiftIf.cmd_target == NEUTRAL) ? 32'(NEUTRAL_TIMEOUT)
                                                         : 32'(SHIFT_TIMEOUT);
            stateNext  = ACTIVE;
          end
        end
      end
      ACTIVE: begin
        // Arrival is checked before the timer so a last-cycle arrival still reports OK.
        if (gear_stable_valid && gear_stable == target) begin
          resultNext = OK;
          stateNext  = REPORT;
        end else if (gear_stable_valid && gear_stable != startGear && gear_stable != BETWEEN) begin
          resultNext = WRONG_GEAR;
          stateNext  = REPORT;
        end else if (timer == '0) begin
          resultNext = TIMEOUT;
          stateNext  = REPORT;
        end else begin
          timerNext = timer - 32'd1;
        end
      end
      REPORT:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gear_shift_monitor.sv
// Directed bench for gear_shift_monitor with short timing parameters and hand-computed latencies.
module tb_gear_shift_monitor;
  import gear_pkg::*;

  localparam int DEB = 4;
  localparam int SHT = 100;
  localparam int NTO = 50;

  logic       clk;
  logic       rst_n;
  logic [2:0] gps_raw;
  gear_e      gear_stable;
  logic       gear_stable_valid;
  logic       fault;
  logic       fault_clr;

  int vecCnt = 0;
  int errCnt = 0;

  gear_shift_if shiftIf();

  gear_shift_monitor #(
    .DEBOUNCE_CYCLES (DEB),
    .SHIFT_TIMEOUT   (SHT),
    .NEUTRAL_TIMEOUT (NTO)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .shiftIf           (shiftIf),
    .gps_raw           (gps_raw),
    .gear_stable       (gear_stable),
    .gear_stable_valid (gear_stable_valid),
    .fault             (fault),
    .fault_clr         (fault_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want summary");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Advance n clock edges; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Move the sensor and wait long enough for it to be published (2 sync + DEB + margin).
  task automatic setGear(input logic [2:0] g);
    gps_raw = g;
    tick(DEB + 4);
  endtask

  // Present a command for one cycle; returns just after the accept edge.
  task automatic sendCmd(input logic dir, input gear_e tgt);
    check("ready_before_cmd", shiftIf.cmd_ready, 1'b1);
    shiftIf.cmd_valid  = 1'b1;
    shiftIf.cmd_dir    = dir;
    shiftIf.cmd_target = tgt;
    tick(1);
    shiftIf.cmd_valid  = 1'b0;
  endtask

  // Counts edges after the accept edge until done is seen, bounded by maxCyc.
  task automatic waitDone(input string tag, input int maxCyc, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < maxCyc) begin
      tick(1);
      cyc++;
      if (shiftIf.done) seen = 1'b1;
    end
    check(tag, seen, 1'b1);
  endtask

  initial begin
    int cyc;
    int doneCnt;

    rst_n              = 1'b0;
    gps_raw            = 3'd0;
    fault_clr          = 1'b0;
    shiftIf.cmd_valid  = 1'b0;
    shiftIf.cmd_dir    = 1'b0;
    shiftIf.cmd_target = NEUTRAL;
    tick(3);

    // Reset state
    check("rst_ready",  shiftIf.cmd_ready, 1'b0);
    check("rst_stable", gear_stable,       NEUTRAL);
    check("rst_valid",  gear_stable_valid, 1'b0);
    check("rst_busy",   shiftIf.busy,      1'b0);
    check("rst_done",   shiftIf.done,      1'b0);
    check("rst_result", shiftIf.result,    OK);
    check("rst_fault",  fault,             1'b0);

    rst_n = 1'b1;
    tick(1);
    check("ready_after_rst", shiftIf.cmd_ready, 1'b1);
    tick(6);
    check("valid_after_hold", gear_stable_valid, 1'b1);
    check("stable_after_hold", gear_stable, NEUTRAL);

    // Glitch: 2 held for only 3 cycles must never reach gear_stable
    gps_raw = 3'd2;
    tick(3);
    gps_raw = 3'd0;
    doneCnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (gear_stable != NEUTRAL) doneCnt++;
    end
    check("glitch_filtered", doneCnt, 0);

    // Sustained edge: published exactly 6 edges after the change
    gps_raw = 3'd2;
    tick(5);
    check("deb_edge5", gear_stable, NEUTRAL);
    tick(1);
    check("deb_edge6", gear_stable, SECOND);

    // Normal upshift 2 -> (BETWEEN) -> 3
    sendCmd(1'b1, THIRD);
    check("up_busy", shiftIf.busy, 1'b1);
    check("up_ready_low", shiftIf.cmd_ready, 1'b0);
    check("up_act_dir", shiftIf.act_dir, 1'b1);
    gps_raw = 3'd7;
    tick(10);
    check("up_in_transit", gear_stable, BETWEEN);
    check("up_still_busy", shiftIf.busy, 1'b1);
    gps_raw = 3'd3;
    waitDone("up_done", 40, cyc);
    check("up_result", shiftIf.result, OK);
    check("up_busy_low", shiftIf.busy, 1'b0);
    check("up_fault", fault, 1'b0);
    tick(1);
    check("up_done_pulse", shiftIf.done, 1'b0);
    check("up_ready_back", shiftIf.cmd_ready, 1'b1);

    // Target already reached at accept: done one edge after the accept edge
    sendCmd(1'b0, THIRD);
    waitDone("same_done", 5, cyc);
    check("same_latency", cyc, 1);
    check("same_result", shiftIf.result, OK);
    tick(1);

    // Neutral timeout: timer loads 50, reaches 0 on the 51st active cycle
    setGear(3'd1);
    sendCmd(1'b0, NEUTRAL);
    waitDone("to_done", 80, cyc);
    check("to_latency", cyc, 51);
    check("to_result", shiftIf.result, TIMEOUT);
    check("to_fault_in_report", fault, 1'b0);
    tick(1);
    check("to_fault_set", fault, 1'b1);
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    check("to_fault_clr", fault, 1'b0);

    // Wrong gear: 3 -> target 4 but the box lands in 5
    setGear(3'd3);
    sendCmd(1'b1, FOURTH);
    gps_raw = 3'd5;
    waitDone("wg_done", 40, cyc);
    check("wg_latency", cyc, 7);
    check("wg_result", shiftIf.result, WRONG_GEAR);
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    check("wg_set_wins", fault, 1'b1);

    // Invalid target goes straight to REPORT
    sendCmd(1'b0, BETWEEN);
    check("bad_done", shiftIf.done, 1'b1);
    check("bad_result", shiftIf.result, BAD_CMD);
    check("bad_busy", shiftIf.busy, 1'b0);
    tick(1);
    check("bad_done_pulse", shiftIf.done, 1'b0);

    // Backpressure: commands while busy are dropped
    sendCmd(1'b1, SIXTH);
    shiftIf.cmd_valid  = 1'b1;
    shiftIf.cmd_target = THIRD;
    tick(1);
    check("bp_ready_low", shiftIf.cmd_ready, 1'b0);
    tick(1);
    shiftIf.cmd_valid = 1'b0;
    check("bp_busy", shiftIf.busy, 1'b1);
    gps_raw = 3'd6;
    waitDone("bp_done", 40, cyc);
    check("bp_result", shiftIf.result, OK);
    doneCnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (shiftIf.done) doneCnt++;
    end
    check("bp_no_second_done", doneCnt, 0);
    check("bp_fault_sticky", fault, 1'b1);

    // Reset mid-shift
    sendCmd(1'b0, FIFTH);
    tick(2);
    check("mid_busy", shiftIf.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",   shiftIf.busy,      1'b0);
    check("mid_rst_stable", gear_stable,       NEUTRAL);
    check("mid_rst_valid",  gear_stable_valid, 1'b0);
    check("mid_rst_fault",  fault,             1'b0);
    check("mid_rst_ready",  shiftIf.cmd_ready, 1'b0);
    doneCnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (shiftIf.done) doneCnt++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (shiftIf.done) doneCnt++;
    end
    check("mid_no_done", doneCnt, 0);
    check("mid_idle_ready", shiftIf.cmd_ready, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

endmodule
